// File: rtl/morse_pkg.sv
// Shared Morse symbol encoding and keyer state definitions.
package morse_pkg;

  localparam logic [2:0] DOT_SYM  = 3'b010;
  localparam logic [2:0] DASH_SYM = 3'b110;
  localparam logic [2:0] MASK_SYM = 3'b000;

  localparam int unsigned SYM_ON_BIT   = 1;
  localparam int unsigned SYM_LONG_BIT = 2;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StMark,
    StGap
  } keyer_state_e;

  // Tone length in units for a symbol with the on bit set.
  function automatic logic [1:0] mark_units(input logic [2:0] sym);
    return sym[SYM_LONG_BIT] ? 2'd3 : 2'd1;
  endfunction

endpackage

// File: rtl/morse_keyer_unit_timer.sv
// Counts a loaded number of time units, each UNIT_CYCLES clocks long, and
// flags the final cycle of the last unit.
module unit_timer #(
  parameter int unsigned UNIT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [1:0] units,
  output logic       done
);

  localparam int unsigned CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(UNIT_CYCLES - 1);

  logic [CW-1:0] cycle_q;
  logic [1:0]    units_q;
  logic          wrap;

  assign wrap = (cycle_q == LAST);
  // units_q is only non-zero while a MARK or GAP is running.
  assign done = wrap && (units_q == 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      units_q <= '0;
    end else if (load) begin
      cycle_q <= '0;
      units_q <= units;
    end else if (units_q != 2'd0) begin
      if (wrap) begin
        cycle_q <= '0;
        units_q <= units_q - 2'd1;
      end else begin
        cycle_q <= cycle_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/morse_keyer.sv
// Pulls Morse symbols from the decoder and turns each into a timed key signal.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 50000,
  parameter int unsigned MASK_UNITS  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] symbol_in,
  output logic       symbol_request,
  output logic       key_out,
  output logic       busy
);

  keyer_state_e state_q, state_d;
  logic         load;
  logic [1:0]   load_units;
  logic         done;
  logic         key_q;
  logic         busy_q;

  unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_unit_timer (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .units(load_units),
    .done (done)
  );

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    load_units = 2'd1;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StFetch;
      end
      StFetch: begin
        load = 1'b1;
        if (symbol_in[SYM_ON_BIT]) begin
          state_d    = StMark;
          load_units = mark_units(symbol_in);
        end else begin
          state_d    = StGap;
          load_units = 2'(MASK_UNITS);
        end
      end
      StMark: begin
        // Every mark is followed by a one-unit intra-character gap.
        if (done) begin
          state_d    = StGap;
          load       = 1'b1;
          load_units = 2'd1;
        end
      end
      StGap: begin
        if (done) state_d = enable ? StFetch : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= (state_d == StMark);
      busy_q  <= (state_d != StIdle);
    end
  end

  // Combinational so the symbol is consumed on the same edge it is requested.
  assign symbol_request = (state_q == StFetch) && !rst;
  assign key_out        = key_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Scoreboard bench: each observed request queues the expected key pattern.
module tb_morse_keyer;
  import morse_pkg::*;

  localparam int unsigned U = 4;
  localparam int unsigned M = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] symbol_in = 3'b000;
  logic       req, key, busy;

  logic       enable1 = 1'b0;
  logic [2:0] symbol_in1 = 3'b010;
  logic       req1, key1, busy1;

  always #5 clk = ~clk;

  morse_keyer #(
    .UNIT_CYCLES(U),
    .MASK_UNITS (M)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .symbol_in     (symbol_in),
    .symbol_request(req),
    .key_out       (key),
    .busy          (busy)
  );

  morse_keyer #(
    .UNIT_CYCLES(1),
    .MASK_UNITS (M)
  ) dut_u1 (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable1),
    .symbol_in     (symbol_in1),
    .symbol_request(req1),
    .key_out       (key1),
    .busy          (busy1)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_reqs = 0;

  logic       exp_q[$];
  logic [1:0] exp1_q[$];
  logic [2:0] src[$];

  bit   sb_on = 1'b1;
  bit   want_req = 1'b0;
  bit   exp_req = 1'b0;
  bit   dash_seen = 1'b0;
  logic last_req, last_key, last_busy;

  task automatic chk(input string tag, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_sym(input logic [2:0] s);
    int mk;
    int gp;
    if (s[1]) begin
      mk = s[2] ? 3 * U : U;
      gp = U;
      if (s[2]) dash_seen = 1'b1;
    end else begin
      mk = 0;
      gp = M * U;
    end
    repeat (mk) exp_q.push_back(1'b1);
    repeat (gp) exp_q.push_back(1'b0);
  endtask

  task automatic tick();
    bit adv;
    logic [1:0] e;
    adv = 1'b0;
    @(negedge clk);
    last_req  = req;
    last_key  = key;
    last_busy = busy;
    if (req) n_reqs++;
    if (exp1_q.size() > 0) begin
      e = exp1_q.pop_front();
      chk("u1_req", req1, int'(e[1]));
      chk("u1_key", key1, int'(e[0]));
    end
    if (sb_on) begin
      if (want_req) begin
        chk("req_due", req, int'(exp_req));
        if (!exp_req) chk("busy_idle", busy, 0);
        want_req = 1'b0;
      end
      if (req) begin
        chk("req_early", exp_q.size(), 0);
        chk("key_fetch", key, 0);
        chk("busy_fetch", busy, 1);
        push_sym(symbol_in);
        adv = 1'b1;
      end else if (exp_q.size() > 0) begin
        chk("key", key, int'(exp_q.pop_front()));
        chk("busy", busy, 1);
        if (exp_q.size() == 0) begin
          want_req = 1'b1;
          exp_req  = enable;
        end
      end
    end
    @(posedge clk);
    #1;
    if (adv) begin
      if (src.size() > 0) void'(src.pop_front());
      symbol_in = (src.size() > 0) ? src[0] : MASK_SYM;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || want_req || busy) && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 200), 1);
  endtask

  initial begin
    int n;
    int r0;

    // Reset state
    tick();
    tick();
    chk("rst_key", last_key, 0);
    chk("rst_req", last_req, 0);
    chk("rst_busy", last_busy, 0);

    // Dot, dash, two mask encodings back to back
    src = '{DOT_SYM, DASH_SYM, MASK_SYM, 3'b100};
    symbol_in = src[0];
    rst = 1'b0;
    enable = 1'b1;
    tick();
    chk("en_lat0", last_req, 0);
    tick();
    chk("en_lat1", last_req, 1);
    n = 0;
    while (src.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    chk("s1_timeout", 32'(n < 200), 1);
    enable = 1'b0;
    wait_idle("s1_idle");
    r0 = n_reqs;
    repeat (6) tick();
    chk("s1_no_req", n_reqs - r0, 0);

    // Enable dropped during a dash
    dash_seen = 1'b0;
    src = '{DOT_SYM, DASH_SYM, MASK_SYM};
    symbol_in = src[0];
    enable = 1'b1;
    n = 0;
    while (!dash_seen && n < 200) begin
      tick();
      n++;
    end
    chk("s2_dash_seen", 32'(dash_seen), 1);
    repeat (3) tick();
    enable = 1'b0;
    wait_idle("s2_idle");
    r0 = n_reqs;
    repeat (8) tick();
    chk("s2_no_req", n_reqs - r0, 0);
    chk("s2_busy", busy, 0);
    chk("s2_unfetched", src.size(), 1);
    src.delete();
    symbol_in = MASK_SYM;

    // Reset in the middle of a dash
    dash_seen = 1'b0;
    src = '{DASH_SYM};
    symbol_in = DASH_SYM;
    enable = 1'b1;
    n = 0;
    while (!dash_seen && n < 200) begin
      tick();
      n++;
    end
    chk("s3_dash_seen", 32'(dash_seen), 1);
    repeat (3) tick();
    sb_on = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    want_req = 1'b0;
    tick();
    chk("rst_pre_req", last_req, 0);
    chk("rst_pre_key", last_key, 1);
    tick();
    chk("rst_mid_key", last_key, 0);
    chk("rst_mid_req", last_req, 0);
    chk("rst_mid_busy", last_busy, 0);
    src = '{DOT_SYM};
    symbol_in = DOT_SYM;
    rst = 1'b0;
    tick();
    chk("rel_lat0", last_req, 0);
    sb_on = 1'b1;
    tick();
    chk("rel_lat1", last_req, 1);
    enable = 1'b0;
    wait_idle("s3_idle");

    // One-cycle units: request every 3 cycles, key 0,1,0
    exp1_q.push_back(2'b00);
    exp1_q.push_back(2'b10);
    repeat (4) begin
      exp1_q.push_back(2'b01);
      exp1_q.push_back(2'b00);
      exp1_q.push_back(2'b10);
    end
    enable1 = 1'b1;
    repeat (14) tick();
    chk("u1_drained", exp1_q.size(), 0);
    enable1 = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/morse_keyer.md
# morse_keyer

Stage directly downstream of the character decoder in the transmit path. It pulls one 3-bit Morse symbol at a time, using the decoder's pull handshake, and turns each symbol into a timed on/off key signal. Dot, dash, intra-character gap and mask (silence) lengths are exact multiples of a programmable time unit. The key signal drives the tone gate / output pin.

## Interface
- `UNIT_CYCLES`, default 50000: clock cycles per Morse time unit; must be ≥ 1.
- `MASK_UNITS`, default 2: silence units produced by a mask symbol; range 1..3.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: allows symbol fetching; sampled in IDLE and at the end of each symbol.
- `symbol_in` in 3: symbol from the decoder's `serial_data`, combinationally valid in the cycle `symbol_request` is high.
- `symbol_request` out 1: one-cycle pull pulse, connected to the decoder's `incoming_request`. The symbol is consumed at the same clock edge.
- `key_out` out 1: registered key/tone gate, 1 = mark.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- Symbol encoding:
  - bit1 = tone on/off; bit2 = long, meaning a dash when bit1 = 1; bit0 is ignored.
  - Dot = 3'b010, dash = 3'b110, mask = 3'b000.
  - Codes with bit1 = 0 (000, 100, 001, 101) are all treated as mask.
- States: IDLE, FETCH, MARK, GAP.
- IDLE
  - `key_out` = 0, `symbol_request` = 0.
  - If `enable` = 1, go to FETCH next cycle.
- FETCH, lasts exactly 1 cycle:
  - `symbol_request` = 1 and `symbol_in` is sampled.
  - bit1 = 1: go to MARK with unit count 3 if bit2 = 1, else 1.
  - bit1 = 0: go to GAP with unit count `MASK_UNITS`.
- MARK
  - `key_out` = 1 for unit count × `UNIT_CYCLES` cycles.
  - Then go to GAP with unit count 1 (intra-character gap).
- GAP
  - `key_out` = 0 for unit count × `UNIT_CYCLES` cycles.
  - At expiry: go to FETCH if `enable` = 1, else IDLE.
- Timing counters:
  - Cycle counter width is max(1, clog2(`UNIT_CYCLES`)); unit counter width is 2.
  - Both clear on every entry into MARK or GAP, so each unit is exact.
  - Cycle counter wraps at `UNIT_CYCLES`−1, decrementing the unit count. The state ends when the last unit wraps.
- `enable` deasserted mid-symbol: the current MARK and its trailing GAP always complete. No symbol is ever truncated.
- `symbol_request` is asserted only in FETCH, never on consecutive cycles, and never while `rst` = 1.

## Timing
- Reset values, at the first edge with `rst` = 1: state IDLE, `key_out` 0, `symbol_request` 0, `busy` 0, all counters 0.
- Reset mid-MARK: `key_out` drops to 0 on that same edge. No request is issued during reset.
- `enable` rising in IDLE at cycle t: FETCH in t+1, so `symbol_request` is high in t+1.
- FETCH at cycle t:
  - `key_out` for the fetched symbol first changes at t+1, because it is registered from the next state.
- Cycles from one FETCH to the next, with U = `UNIT_CYCLES`:
  - Dot: 1 + 2U.
  - Dash: 1 + 4U.
  - Mask: 1 + `MASK_UNITS`·U.
- With U = 1: every unit is a single cycle, and the counter never counts beyond 0.
- `busy` is registered and changes on the same edge as the state.

## Structure
- Shared Morse package/include holds:
  - Symbol constants: `DOT_SYM`, `DASH_SYM`, `MASK_SYM`.
  - Bit indices: `SYM_ON_BIT` = 1, `SYM_LONG_BIT` = 2.
  - Keyer state encoding.
- One natural sub-module: `unit_timer`.
  - Ports: `load`, `units`.
  - Contains the cycle and unit counters and outputs `done`.
- FSM and output registers live in `morse_keyer`.

## Test plan
All scenarios use U = 4, `MASK_UNITS` = 2 and a scripted symbol source.
- Reset then `enable` = 1 with source 010:
  - `symbol_request` at cycle 1.
  - `key_out` high cycles 2–5, low 6–9.
  - Next request at cycle 10.
- Source 110: `key_out` high 12 cycles, low 4, then the next request.
- Source 000, then 100: `key_out` stays 0 for 8 cycles each, with requests 9 cycles apart.
- Sequence 010, 110, 000 with `enable` dropped during the dash:
  - Dash and its 4-cycle gap complete.
  - No further request is issued; `busy` falls and the state returns to IDLE.
- `rst` asserted in the middle of a dash:
  - `key_out` = 0 and `symbol_request` = 0 from that edge.
  - After release with `enable` = 1, the first request comes exactly 2 cycles later.
- U = 1, source 010 repeated: requests every 3 cycles; `key_out` pattern 0,1,0 repeating.
